// File: rtl/led_panel_pkg.sv
// Shared types and helpers for the 2x4 RYGB LED panel controller.
// Optional RED_COUNT output is enabled with LED_PANEL_RED_COUNT_EN.
package led_panel_pkg;

   typedef enum logic [1:0] {
      BLU = 2'd0,
      GRN = 2'd1,
      YEL = 2'd2,
      RED = 2'd3
   } LED_t;

   localparam int ROWS_DEF = 2;
   localparam int COLS_DEF = 4;

   // Upper bound on panel size; smaller panels are zero-extended (all BLU) into PANEL_t.
   localparam int MAX_LEDS = 64;
   typedef logic [2*MAX_LEDS-1:0] PANEL_t;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WALK_STEP = 2'd1;
   localparam logic [1:0] ST_WALK_DONE = 2'd2;

   function automatic logic is_red_present(input PANEL_t p);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < MAX_LEDS; i++) begin
         if (LED_t'(p[2*i +: 2]) == RED) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/led_panel_monitor.sv
// Panel status monitor: registered DANGER, saturating ALERTS counter and,
// with LED_PANEL_RED_COUNT_EN, a registered count of RED LEDs.
module led_panel_monitor
   import led_panel_pkg::*;
#(
   parameter int N       = 8,
   parameter int ALERT_W = 16
)(
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [2*N-1:0]           PANEL,
   input  logic                     PANEL_UPD,
   input  logic                     CLR_ALERTS,
   output logic                     DANGER,
   output logic [ALERT_W-1:0]       ALERTS
`ifdef LED_PANEL_RED_COUNT_EN
   ,
   output logic [$clog2(N+1)-1:0]   RED_COUNT
`endif
);

   PANEL_t pext;
   logic   red_now;

   always_comb begin
      pext          = '0;
      pext[2*N-1:0] = PANEL;
   end

   assign red_now = is_red_present(pext);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         DANGER <= 1'b0;
         ALERTS <= '0;
      end else begin
         DANGER <= red_now;
         if (CLR_ALERTS)
            ALERTS <= '0;
         else if (PANEL_UPD && red_now && (ALERTS != '1))
            ALERTS <= ALERTS + 1'b1;
      end
   end

`ifdef LED_PANEL_RED_COUNT_EN
   logic [$clog2(N+1)-1:0] red_cnt;

   always_comb begin
      red_cnt = '0;
      for (int i = 0; i < N; i++) begin
         if (LED_t'(PANEL[2*i +: 2]) == RED) red_cnt = red_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) RED_COUNT <= '0;
      else     RED_COUNT <= red_cnt;
   end
`endif

endmodule

// File: rtl/led_panel_ctrl.sv
// LED panel controller: single-LED write port, walking-red self-test and status monitor.
// Define LED_PANEL_RED_COUNT_EN to add the RED_COUNT output.
//
// state        | meaning
// ST_IDLE      | accepting writes and walk starts
// ST_WALK_STEP | RED held at index idx for STEP_CYCLES cycles
// ST_WALK_DONE | all-background pattern shown, one cycle before IDLE
module led_panel_ctrl
   import led_panel_pkg::*;
#(
   parameter int ROWS        = ROWS_DEF,
   parameter int COLS        = COLS_DEF,
   parameter int STEP_CYCLES = 10,
   parameter int ALERT_W     = 16
)(
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           WR_VALID,
   output logic                           WR_READY,
   input  logic [$clog2(ROWS)-1:0]        WR_ROW,
   input  logic [$clog2(COLS)-1:0]        WR_COL,
   input  logic [1:0]                     WR_COLOR,
   input  logic                           WALK_START,
   input  logic [1:0]                     WALK_BKGND,
   output logic                           WALK_BUSY,
   input  logic                           CLR_ALERTS,
   output logic [ROWS*COLS*2-1:0]         PANEL,
   output logic                           PANEL_UPD,
   output logic                           DANGER,
   output logic [ALERT_W-1:0]             ALERTS
`ifdef LED_PANEL_RED_COUNT_EN
   ,
   output logic [$clog2(ROWS*COLS+1)-1:0] RED_COUNT
`endif
);

   localparam int N  = ROWS * COLS;
   localparam int PW = 2 * N;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int DW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] panel_q, panel_d;
   logic [1:0]    bkgnd_q, bkgnd_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic          upd_q;
   logic          wr_in_range;
   int            widx;

   // A position at or beyond N yields the plain background.
   function automatic logic [PW-1:0] walk_pattern(input logic [1:0] bk, input int pos);
      logic [PW-1:0] r;
      for (int i = 0; i < N; i++) r[2*i +: 2] = (i == pos) ? 2'(RED) : bk;
      return r;
   endfunction

   assign wr_in_range = (int'(WR_ROW) < ROWS) && (int'(WR_COL) < COLS);

   // Walk start wins over a same-cycle write, so READY drops to keep the write pending.
   assign WR_READY  = !RST && (state_q == ST_IDLE) && !WALK_START;
   assign WALK_BUSY = (state_q != ST_IDLE);
   assign PANEL     = panel_q;
   assign PANEL_UPD = upd_q;

   always_comb begin
      state_d = state_q;
      panel_d = panel_q;
      bkgnd_d = bkgnd_q;
      idx_d   = idx_q;
      dwell_d = dwell_q;
      widx    = int'(WR_ROW) * COLS + int'(WR_COL);
      case (state_q)
         ST_IDLE: begin
            if (WALK_START) begin
               bkgnd_d = (LED_t'(WALK_BKGND) == RED) ? 2'(BLU) : WALK_BKGND;
               idx_d   = '0;
               dwell_d = DW'(STEP_CYCLES - 1);
               panel_d = walk_pattern(bkgnd_d, 0);
               state_d = ST_WALK_STEP;
            end else if (WR_VALID && wr_in_range) begin
               panel_d[2*widx +: 2] = WR_COLOR;
            end
         end
         ST_WALK_STEP: begin
            if (dwell_q == '0) begin
               dwell_d = DW'(STEP_CYCLES - 1);
               if (int'(idx_q) == N - 1) begin
                  panel_d = walk_pattern(bkgnd_q, N);
                  state_d = ST_WALK_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  panel_d = walk_pattern(bkgnd_q, int'(idx_q) + 1);
               end
            end else begin
               dwell_d = dwell_q - 1'b1;
            end
         end
         ST_WALK_DONE: state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         panel_q <= '0;
         bkgnd_q <= '0;
         idx_q   <= '0;
         dwell_q <= '0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         panel_q <= panel_d;
         bkgnd_q <= bkgnd_d;
         idx_q   <= idx_d;
         dwell_q <= dwell_d;
         upd_q   <= (panel_d != panel_q);
      end
   end

   led_panel_monitor #(
      .N       (N),
      .ALERT_W (ALERT_W)
   ) u_monitor (
      .CLK        (CLK),
      .RST        (RST),
      .PANEL      (panel_q),
      .PANEL_UPD  (upd_q),
      .CLR_ALERTS (CLR_ALERTS),
      .DANGER     (DANGER),
      .ALERTS     (ALERTS)
`ifdef LED_PANEL_RED_COUNT_EN
      ,
      .RED_COUNT  (RED_COUNT)
`endif
   );

endmodule

// File: tb/tb_led_panel_ctrl.sv
// Directed bench for led_panel_ctrl; a second instance with ALERT_W=2 shares all inputs.
// RED_COUNT is checked when LED_PANEL_RED_COUNT_EN is defined.
module tb_led_panel_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        WR_VALID = 1'b0;
   logic        WR_ROW = 1'b0;
   logic [1:0]  WR_COL = 2'd0;
   logic [1:0]  WR_COLOR = 2'd0;
   logic        WALK_START = 1'b0;
   logic [1:0]  WALK_BKGND = 2'd0;
   logic        CLR_ALERTS = 1'b0;

   logic        WR_READY, WALK_BUSY, PANEL_UPD, DANGER;
   logic [15:0] PANEL;
   logic [15:0] ALERTS;
   logic        WR_READY2, WALK_BUSY2, PANEL_UPD2, DANGER2;
   logic [15:0] PANEL2;
   logic [1:0]  ALERTS2;
`ifdef LED_PANEL_RED_COUNT_EN
   logic [3:0]  RED_COUNT, RED_COUNT2;
`endif

   int checks = 0;
   int errors = 0;

   led_panel_ctrl u_dut (
      .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_READY(WR_READY),
      .WR_ROW(WR_ROW), .WR_COL(WR_COL), .WR_COLOR(WR_COLOR),
      .WALK_START(WALK_START), .WALK_BKGND(WALK_BKGND), .WALK_BUSY(WALK_BUSY),
      .CLR_ALERTS(CLR_ALERTS), .PANEL(PANEL), .PANEL_UPD(PANEL_UPD),
      .DANGER(DANGER), .ALERTS(ALERTS)
`ifdef LED_PANEL_RED_COUNT_EN
      , .RED_COUNT(RED_COUNT)
`endif
   );

   led_panel_ctrl #(.ALERT_W(2)) u_sat (
      .CLK(CLK), .RST(RST), .WR_VALID(WR_VALID), .WR_READY(WR_READY2),
      .WR_ROW(WR_ROW), .WR_COL(WR_COL), .WR_COLOR(WR_COLOR),
      .WALK_START(WALK_START), .WALK_BKGND(WALK_BKGND), .WALK_BUSY(WALK_BUSY2),
      .CLR_ALERTS(CLR_ALERTS), .PANEL(PANEL2), .PANEL_UPD(PANEL_UPD2),
      .DANGER(DANGER2), .ALERTS(ALERTS2)
`ifdef LED_PANEL_RED_COUNT_EN
      , .RED_COUNT(RED_COUNT2)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic r, input logic [1:0] c, input logic [1:0] color);
      WR_ROW = r; WR_COL = c; WR_COLOR = color; WR_VALID = 1'b1;
      tick;
      WR_VALID = 1'b0;
   endtask

   function automatic logic [15:0] pat(input logic [1:0] bk, input int p);
      logic [15:0] r;
      for (int i = 0; i < 8; i++) r[2*i +: 2] = (i == p) ? 2'b11 : bk;
      return r;
   endfunction

   // Called at the first sample after the walk-start edge (c = 0); returns at c = 82.
   task automatic run_walk(input logic [1:0] bk, input int a0);
      int busy;
      int exp_a;
      int inc;
      busy = 0;
      for (int c = 0; c <= 81; c++) begin
         inc   = (c == 0) ? 0 : (((c + 9) / 10 > 8) ? 8 : (c + 9) / 10);
         exp_a = a0 + inc;
         chk("walk_panel", PANEL, pat(bk, (c <= 80) ? c / 10 : 8));
         chk("walk_upd", PANEL_UPD, (c <= 80) && (c % 10 == 0));
         chk("walk_ready", WR_READY, c == 81);
         chk("walk_alerts", ALERTS, exp_a);
         chk("walk_alerts_sat", ALERTS2, (exp_a > 3) ? 3 : exp_a);
         if (c >= 1) chk("walk_danger", DANGER, c <= 80);
`ifdef LED_PANEL_RED_COUNT_EN
         if (c >= 1) chk("walk_red_count", RED_COUNT, (c <= 80) ? 1 : 0);
`endif
         if (WALK_BUSY) busy++;
         WALK_START = (c == 35);
         tick;
      end
      WALK_START = 1'b0;
      chk("walk_busy_cycles", busy, 81);
   endtask

   initial begin
      // Reset values
      tick; tick;
      chk("rst_panel", PANEL, 16'h0000);
      chk("rst_upd", PANEL_UPD, 0);
      chk("rst_danger", DANGER, 0);
      chk("rst_alerts", ALERTS, 0);
      chk("rst_busy", WALK_BUSY, 0);
      chk("rst_ready", WR_READY, 0);
`ifdef LED_PANEL_RED_COUNT_EN
      chk("rst_red_count", RED_COUNT, 0);
`endif
      RST = 1'b0;
      #1 chk("ready_after_rst", WR_READY, 1);
      tick;

      wr(1'b0, 2'd1, 2'd2);
      chk("wr_yel_panel", PANEL, 16'h0008);
      chk("wr_yel_upd", PANEL_UPD, 1);

      // Mid-cycle reset with a write pending
      #2 WR_VALID = 1'b1; RST = 1'b1;
      #1;
      chk("midrst_panel", PANEL, 16'h0000);
      chk("midrst_ready", WR_READY, 0);
      chk("midrst_danger", DANGER, 0);
      chk("midrst_alerts", ALERTS, 0);
      WR_VALID = 1'b0;
      tick;
      RST = 1'b0;
      #1 chk("midrst_ready_after", WR_READY, 1);
      tick;

      // RED at (1,2) then rewrite the same value
      wr(1'b1, 2'd2, 2'd3);
      chk("red_panel", PANEL, 16'h3000);
      chk("red_upd", PANEL_UPD, 1);
      chk("red_danger_lag", DANGER, 0);
      chk("red_alerts_lag", ALERTS, 0);
      tick;
      chk("red_danger", DANGER, 1);
      chk("red_alerts", ALERTS, 1);
      chk("red_upd_clear", PANEL_UPD, 0);
      wr(1'b1, 2'd2, 2'd3);
      chk("rewrite_upd", PANEL_UPD, 0);
      chk("rewrite_panel", PANEL, 16'h3000);
      tick;
      chk("rewrite_alerts", ALERTS, 1);

      wr(1'b1, 2'd2, 2'd0);
      chk("blu_panel", PANEL, 16'h0000);
      tick;
      chk("blu_danger", DANGER, 0);
      chk("blu_alerts", ALERTS, 1);

      // Walk with GRN background; a same-cycle write stays pending
      WALK_BKGND = 2'd1; WALK_START = 1'b1;
      WR_ROW = 1'b0; WR_COL = 2'd3; WR_COLOR = 2'd2; WR_VALID = 1'b1;
      #1 chk("walk_vs_write_ready", WR_READY, 0);
      tick;
      WALK_START = 1'b0;
      chk("walk_busy_start", WALK_BUSY, 1);
      run_walk(2'd1, 1);
      WR_VALID = 1'b0;
      chk("pending_write_panel", PANEL, 16'h5595);
      chk("pending_write_upd", PANEL_UPD, 1);

      // Clear wins over increment, then saturation of the 2-bit counter
      wr(1'b0, 2'd0, 2'd3);
      CLR_ALERTS = 1'b1;
      tick;
      CLR_ALERTS = 1'b0;
      chk("clr_alerts", ALERTS, 0);
      chk("clr_alerts_sat", ALERTS2, 0);
      for (int k = 0; k < 4; k++) begin
         wr(1'b0, 2'd1, (k % 2 == 0) ? 2'd3 : 2'd1);
         tick;
      end
      chk("four_red_alerts", ALERTS, 4);
      chk("four_red_alerts_sat", ALERTS2, 3);

      // Walk with RED background forced to BLU
      WALK_BKGND = 2'd3; WALK_START = 1'b1;
      tick;
      WALK_START = 1'b0;
      run_walk(2'd0, 4);
      chk("red_bkgnd_final", PANEL, 16'h0000);

      // Reset in the middle of a walk
      WALK_BKGND = 2'd2; WALK_START = 1'b1;
      tick;
      WALK_START = 1'b0;
      for (int k = 0; k < 15; k++) tick;
      chk("abort_busy_before", WALK_BUSY, 1);
      chk("abort_panel_before", PANEL, pat(2'd2, 1));
      #2 RST = 1'b1;
      #1;
      chk("abort_panel", PANEL, 16'h0000);
      chk("abort_busy", WALK_BUSY, 0);
      chk("abort_alerts", ALERTS, 0);
      chk("abort_alerts_sat", ALERTS2, 0);
      tick;
      RST = 1'b0;
      #1 chk("abort_ready", WR_READY, 1);
      tick;
      chk("abort_idle_busy", WALK_BUSY, 0);
      chk("abort_idle_panel", PANEL, 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
